// File: rtl/tc_wb_collect.sv
// Writeback collector: packs LANES consecutive FP-add results into one entry and queues it for the register file.
// Optional ctrl-mismatch check within an entry is enabled with TC_WB_MISMATCH_CHK_EN.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

module tc_wb_collect #(
  parameter int unsigned EXPWIDTH   = 5,
  parameter int unsigned PRECISION  = 11,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid_i,
  output logic                                      in_ready_o,
  input  logic [EXPWIDTH+PRECISION-1:0]             in_result_i,
  input  logic [4:0]                                in_fflags_i,
  input  logic [7:0]                                in_reg_idxw_i,
  input  logic [`DEPTH_WARP-1:0]                    in_warpid_i,
  input  logic                                      flush_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [LANES*(EXPWIDTH+PRECISION)-1:0]     out_data_o,
  output logic [4:0]                                out_fflags_o,
  output logic [7:0]                                out_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0]                    out_warpid_o,
  output logic                                      out_err_o
);

  localparam int unsigned W  = EXPWIDTH + PRECISION;
  localparam int unsigned DW = LANES * W;
  localparam int unsigned WW = `DEPTH_WARP;
  localparam int unsigned CW = $clog2(LANES);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [CW-1:0]                  lane_cnt;
  logic [LANES-2:0][W-1:0]        slots;
  logic [4:0]                     acc_fflags;
  logic [7:0]                     cap_reg;
  logic [WW-1:0]                  cap_warp;

  logic [FIFO_DEPTH-1:0][DW-1:0]  mem_data;
  logic [FIFO_DEPTH-1:0][4:0]     mem_fflags;
  logic [FIFO_DEPTH-1:0][7:0]     mem_reg;
  logic [FIFO_DEPTH-1:0][WW-1:0]  mem_warp;
  logic [PW-1:0]                  wr_ptr;
  logic [PW-1:0]                  rd_ptr;
  logic [PW:0]                    count;

  logic            last_lane;
  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic [DW-1:0]   push_data;
  logic [4:0]      push_fflags;

  assign last_lane   = (lane_cnt == CW'(LANES - 1));
  assign full        = (count == (PW+1)'(FIFO_DEPTH));
  assign in_ready_o  = !flush_i && (!last_lane || !full || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign push        = accept && last_lane;
  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o && out_ready_i;
  // The last lane bypasses the slot registers straight into the FIFO.
  assign push_data   = {in_result_i, slots};
  assign push_fflags = acc_fflags | in_fflags_i;

  // Partial entry assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt   <= '0;
      slots      <= '0;
      acc_fflags <= '0;
      cap_reg    <= '0;
      cap_warp   <= '0;
    end else if (flush_i) begin
      lane_cnt   <= '0;
      acc_fflags <= '0;
    end else if (accept) begin
      lane_cnt <= last_lane ? '0 : lane_cnt + CW'(1);
      if (lane_cnt == '0) begin
        acc_fflags <= in_fflags_i;
        cap_reg    <= in_reg_idxw_i;
        cap_warp   <= in_warpid_i;
      end else begin
        acc_fflags <= push_fflags;
      end
      for (int unsigned i = 0; i < LANES - 1; i++) begin
        if (lane_cnt == CW'(i)) slots[i] <= in_result_i;
      end
    end
  end

  // Completed-entry FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data   <= '0;
      mem_fflags <= '0;
      mem_reg    <= '0;
      mem_warp   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr]   <= push_data;
        mem_fflags[wr_ptr] <= push_fflags;
        mem_reg[wr_ptr]    <= cap_reg;
        mem_warp[wr_ptr]   <= cap_warp;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_data_o     = out_valid_o ? mem_data[rd_ptr]   : '0;
  assign out_fflags_o   = out_valid_o ? mem_fflags[rd_ptr] : '0;
  assign out_reg_idxw_o = out_valid_o ? mem_reg[rd_ptr]    : '0;
  assign out_warpid_o   = out_valid_o ? mem_warp[rd_ptr]   : '0;

`ifdef TC_WB_MISMATCH_CHK_EN
  logic                  acc_err;
  logic                  mismatch;
  logic                  push_err;
  logic [FIFO_DEPTH-1:0] mem_err;

  assign mismatch = (lane_cnt != '0) &&
                    ((in_reg_idxw_i != cap_reg) || (in_warpid_i != cap_warp));
  assign push_err = acc_err | mismatch;

  // Sticky per-entry error, restarted at lane 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_err <= 1'b0;
      mem_err <= '0;
    end else begin
      if (flush_i)     acc_err <= 1'b0;
      else if (accept) acc_err <= (lane_cnt == '0) ? 1'b0 : push_err;
      if (push) mem_err[wr_ptr] <= push_err;
    end
  end

  assign out_err_o = out_valid_o & mem_err[rd_ptr];
`else
  assign out_err_o = 1'b0;
`endif

endmodule
